// File: rtl/sync_fifo_pkg.sv
// Shared constants and pointer-compare helpers for the sync_fifo block.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 8;

  // Pointers are passed zero-extended to 32 bits so one helper serves every depth.
  function automatic logic ptr_empty(input logic [31:0] wr, input logic [31:0] rd);
    return (wr == rd);
  endfunction

  // Full when the address bits match and only the wrap bit (bit aw) differs.
  function automatic logic ptr_full(input logic [31:0] wr, input logic [31:0] rd,
                                    input int unsigned aw);
    return ((wr ^ rd) == (32'd1 << aw));
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH storage with one write port and one registered read port.
// Storage is never reset; only the read-data register is cleared.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Write port: capture data into the addressed entry.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port: one-cycle latency, holds its value when no read is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock synchronous FIFO: pointers, status flags, accept logic.
// Optional sticky overflow/underflow outputs are enabled by defining FIFO_ERR_FLAGS_EN.
// DEPTH must be a power of two and at least 2.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_op,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic                  empty,
  output logic                  full
);

  localparam logic [ADDR_WIDTH:0] PTR_INC = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic                wr_ok, rd_ok;

  assign empty = ptr_empty(32'(wr_ptr_q), 32'(rd_ptr_q));
  assign full  = ptr_full(32'(wr_ptr_q), 32'(rd_ptr_q), ADDR_WIDTH);

  // A read at full frees a slot in the same edge, so a write is still taken.
  // Both accepts are gated off while reset is asserted.
  assign rd_ok = rst && rd_en && !empty;
  assign wr_ok = rst && wr_en && (!full || rd_ok);

  // Next-state pointers: natural rollover provides the wrap bit.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_INC;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_INC;
  end

  // Pointer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (data_in),
    .re    (rd_ok),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (data_op)
  );

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error next-state: dropped write, or read request while empty.
  always_comb begin
    overflow_d  = overflow_q  | (wr_en && full && !rd_ok);
    underflow_d = underflow_q | (rd_en && empty);
  end

  // Sticky error registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] data_op;
  logic          empty;
  logic          full;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .data_op   (data_op),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow  (overflow),
    .underflow (underflow),
`endif
    .empty     (empty),
    .full      (full)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: contents as a queue, last read word, sticky error bits.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dop;
  bit            m_ovf;
  bit            m_unf;

  typedef struct {
    bit            rst;
    bit            wr;
    bit            rd;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_dop;
    bit            exp_empty;
    bit            exp_full;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, and wait until just after the edge.
  task automatic apply(input bit r, input bit w, input bit rd, input logic [DW-1:0] d);
    bit rok, wok;
    rst = r; wr_en = w; rd_en = rd; data_in = d;
    if (!r) begin
      mq.delete();
      m_dop = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rok = rd && (mq.size() != 0);
      wok = w && ((mq.size() != DEPTH) || rok);
      if (rd && mq.size() == 0) m_unf = 1'b1;
      if (w && !wok) m_ovf = 1'b1;
      if (rok) m_dop = mq.pop_front();
      if (wok) mq.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".data_op"}, 32'(data_op), 32'(m_dop));
    check({tag, ".empty"},   32'(empty),   32'(mq.size() == 0));
    check({tag, ".full"},    32'(full),    32'(mq.size() == DEPTH));
`ifdef FIFO_ERR_FLAGS_EN
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    m_dop = '0; m_ovf = 1'b0; m_unf = 1'b0;

    // Fill/drain table: 8 writes, dropped 9th write, 8 reads, ignored 9th read.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 1'b1, 1'b0, 8'(i + 1), 8'h00, 1'b0, (i == 7)};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++)
      tbl[9 + i] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'(i + 1), (i == 7), 1'b0};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h08, 1'b1, 1'b0};

    // 1. Reset held with random requests.
    for (int i = 0; i < 15; i++) begin
      apply(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      check("rst.empty",   32'(empty),   32'd1);
      check("rst.full",    32'(full),    32'd0);
      check("rst.data_op", 32'(data_op), 32'd0);
    end
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    check("rst_release.empty", 32'(empty), 32'd1);

    // 2. Fill/drain from the table.
    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].din);
      check("tbl.data_op", 32'(data_op), 32'(tbl[i].exp_dop));
      check("tbl.empty",   32'(empty),   32'(tbl[i].exp_empty));
      check("tbl.full",    32'(full),    32'(tbl[i].exp_full));
      check_model("tbl");
    end
`ifdef FIFO_ERR_FLAGS_EN
    check("fill.overflow",  32'(overflow),  32'd1);
    check("fill.underflow", 32'(underflow), 32'd1);
`endif

    // 3. Wrap: single write then single read, 20 times.
    for (int i = 0; i < 20; i++) begin
      apply(1'b1, 1'b1, 1'b0, 8'(8'h10 + i));
      check("wrap.full_w", 32'(full), 32'd0);
      apply(1'b1, 1'b0, 1'b1, 8'h00);
      check("wrap.data_op", 32'(data_op), 32'(8'h10 + i));
      check("wrap.empty",   32'(empty),   32'd1);
    end

    // 4. Simultaneous read/write at full.
    for (int i = 0; i < 8; i++) apply(1'b1, 1'b1, 1'b0, 8'(8'hA0 + i));
    check("sfull.pre_full", 32'(full), 32'd1);
    apply(1'b1, 1'b1, 1'b1, 8'hB0);
    check("sfull.data_op", 32'(data_op), 32'hA0);
    check("sfull.full",    32'(full),    32'd1);
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1'b0, 1'b1, 8'h00);
      check("sfull.drain", 32'(data_op), (i < 7) ? 32'(8'hA1 + i) : 32'hB0);
    end
    check("sfull.empty", 32'(empty), 32'd1);

    // 5. Simultaneous read/write at empty: only the write is taken.
    apply(1'b1, 1'b1, 1'b1, 8'h55);
    check("sempty.data_op", 32'(data_op), 32'hB0);
    check("sempty.empty",   32'(empty),   32'd0);
    apply(1'b1, 1'b0, 1'b1, 8'h00);
    check("sempty.read", 32'(data_op), 32'h55);
    check_model("sempty");

    // 6. Reset in the middle of traffic.
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b1, 1'b0, 8'(8'h30 + i));
    check("midrst.pre_empty", 32'(empty), 32'd0);
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    check("midrst.empty",   32'(empty),   32'd1);
    check("midrst.data_op", 32'(data_op), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    check("midrst.overflow",  32'(overflow),  32'd0);
    check("midrst.underflow", 32'(underflow), 32'd0);
`endif
    apply(1'b1, 1'b0, 1'b1, 8'h00);
    check("midrst.read_data", 32'(data_op), 32'd0);
    check("midrst.read_empty", 32'(empty), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
    check("midrst.underflow_set", 32'(underflow), 32'd1);
`endif

    // Randomized traffic with varying write/read bias and rare resets.
    for (int i = 0; i < 600; i++) begin
      int wbias;
      bit r, w, rd;
      wbias = ((i / 100) % 2 == 0) ? 70 : 30;
      r  = ($urandom_range(0, 99) >= 2);
      w  = ($urandom_range(0, 99) < wbias);
      rd = ($urandom_range(0, 99) < (100 - wbias));
      apply(r, w, rd, 8'($urandom));
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
